// File: rtl/zap_predecode_uop_sequencer_pkg.sv
// Shared predecode definitions: sequencer state encoding and the
// micro-op count saturation rule used when an expansion starts.
package zap_predecode_uop_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } seq_state_t;

  // A zero count still issues the instruction once; anything above the
  // hardware limit is clipped so the index counter can never overflow.
  function automatic int unsigned sat_uop_count(input int unsigned cnt,
                                                input int unsigned max_uops);
    if (cnt == 0)             return 1;
    else if (cnt > max_uops)  return max_uops;
    else                      return cnt;
  endfunction

endpackage

// File: rtl/zap_predecode_uop_sequencer.sv
// Expands one predecoded instruction into up to MAX_UOPS micro-ops by
// tagging it with an index while holding the upstream stage.
module zap_predecode_uop_sequencer
  import zap_predecode_uop_sequencer_pkg::*;
#(
  parameter  int INST_WIDTH = 35,
  parameter  int MAX_UOPS   = 4,
  localparam int IDX_W      = $clog2(MAX_UOPS)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_data_stall,
  input  logic                        i_clear_from_alu,
  input  logic                        i_stall_from_shifter,
  input  logic                        i_stall_from_issue,
  input  logic [INST_WIDTH-1:0]       i_instruction,
  input  logic                        i_instruction_valid,
  input  logic [IDX_W:0]              i_uop_count,
  input  logic                        i_irq,
  input  logic                        i_fiq,
  output logic [INST_WIDTH+IDX_W-1:0] o_instruction,
  output logic                        o_instruction_valid,
  output logic                        o_last_uop,
  output logic                        o_stall_from_decode,
  output logic                        o_irq,
  output logic                        o_fiq
);

  localparam int CNT_W = IDX_W + 1;

  seq_state_t       state_ff, state_nxt, adv_state;
  logic [IDX_W-1:0] idx_ff, idx_nxt, adv_idx, out_idx;
  logic [CNT_W-1:0] cnt_ff, cnt_nxt, adv_cnt, eff_cnt;
  logic             more_uops;

  // Saturated micro-op count for the instruction currently presented.
  always_comb eff_cnt = CNT_W'(sat_uop_count(32'(i_uop_count), 32'(MAX_UOPS)));

  // True while the current index is not yet the final micro-op.
  always_comb more_uops = ({1'b0, idx_ff} < (cnt_ff - CNT_W'(1)));

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_ff <= IDLE;
      idx_ff   <= '0;
      cnt_ff   <= '0;
    end else begin
      state_ff <= state_nxt;
      idx_ff   <= idx_nxt;
      cnt_ff   <= cnt_nxt;
    end
  end

  // Output decode, advance target, then clear/stall priority on the update.
  always_comb begin
    adv_state           = state_ff;
    adv_idx             = idx_ff;
    adv_cnt             = cnt_ff;
    out_idx             = '0;
    o_instruction_valid = i_instruction_valid;
    o_last_uop          = 1'b0;
    o_stall_from_decode = 1'b0;
    o_irq               = i_irq;
    o_fiq               = i_fiq;

    case (state_ff)
      IDLE: begin
        if (i_instruction_valid) begin
          if (eff_cnt == CNT_W'(1)) begin
            o_last_uop = 1'b1;
          end else begin
            o_stall_from_decode = 1'b1;
            adv_state           = BUSY;
            adv_idx             = IDX_W'(1);
            adv_cnt             = eff_cnt;
          end
        end
      end
      BUSY: begin
        // Interrupts are masked mid-expansion so they land on a whole
        // instruction boundary.
        out_idx = idx_ff;
        o_irq   = 1'b0;
        o_fiq   = 1'b0;
        if (more_uops) begin
          o_stall_from_decode = 1'b1;
          adv_idx             = idx_ff + IDX_W'(1);
        end else begin
          o_last_uop = 1'b1;
          adv_state  = IDLE;
          adv_idx    = '0;
        end
      end
      default: ;
    endcase

    state_nxt = state_ff;
    idx_nxt   = idx_ff;
    cnt_nxt   = cnt_ff;
    if (i_clear_from_writeback) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else if (i_data_stall) begin
      // hold
    end else if (i_clear_from_alu) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else if (i_stall_from_shifter || i_stall_from_issue) begin
      // hold
    end else begin
      state_nxt = adv_state;
      idx_nxt   = adv_idx;
      cnt_nxt   = adv_cnt;
    end
  end

  assign o_instruction = {out_idx, i_instruction};

endmodule

// File: tb/tb_zap_predecode_uop_sequencer.sv
// Table-driven bench with an expected-result queue for the uop sequencer.
module tb_zap_predecode_uop_sequencer;

  localparam int IW = 35;
  localparam int MU = 4;
  localparam int XW = 2;

  localparam logic [5:0] C0   = 6'b000000;
  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] CWB  = 6'b010000;
  localparam logic [5:0] DST  = 6'b001000;
  localparam logic [5:0] CALU = 6'b000100;
  localparam logic [5:0] SSH  = 6'b000010;
  localparam logic [5:0] SIS  = 6'b000001;

  typedef struct {
    logic [5:0] ctl;
    logic       vld;
    logic [2:0] cnt;
    logic       irq, fiq;
    logic [1:0] e_idx;
    logic       e_vld, e_last, e_stall, e_irq, e_fiq;
    logic       chk;
  } vec_t;

  typedef struct {
    logic            chk;
    int              tag;
    logic [IW+XW-1:0] ins;
    logic            vld, last, stall, irq, fiq;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu;
  logic              i_stall_from_shifter, i_stall_from_issue;
  logic [IW-1:0]     i_instruction;
  logic              i_instruction_valid;
  logic [XW:0]       i_uop_count;
  logic              i_irq, i_fiq;
  logic [IW+XW-1:0]  o_instruction;
  logic              o_instruction_valid, o_last_uop, o_stall_from_decode, o_irq, o_fiq;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  zap_predecode_uop_sequencer #(.INST_WIDTH(IW), .MAX_UOPS(MU)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
    .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
    .i_stall_from_issue(i_stall_from_issue), .i_instruction(i_instruction),
    .i_instruction_valid(i_instruction_valid), .i_uop_count(i_uop_count),
    .i_irq(i_irq), .i_fiq(i_fiq), .o_instruction(o_instruction),
    .o_instruction_valid(o_instruction_valid), .o_last_uop(o_last_uop),
    .o_stall_from_decode(o_stall_from_decode), .o_irq(o_irq), .o_fiq(o_fiq)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t mk(logic [5:0] ctl, logic vld, logic [2:0] cnt, logic irq,
                              logic fiq, logic [1:0] ei, logic ev, logic el, logic es,
                              logic eq, logic ef, logic chk);
    vec_t v;
    v.ctl = ctl; v.vld = vld; v.cnt = cnt; v.irq = irq; v.fiq = fiq;
    v.e_idx = ei; v.e_vld = ev; v.e_last = el; v.e_stall = es; v.e_irq = eq; v.e_fiq = ef;
    v.chk = chk;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare at negedge.
  task automatic step(input vec_t v, input int tag);
    exp_t e, g;
    logic [IW-1:0] ins;
    ins = {3'b101, 32'hA5A5_0000 + 32'(tag)};
    {i_reset, i_clear_from_writeback, i_data_stall, i_clear_from_alu,
     i_stall_from_shifter, i_stall_from_issue} = v.ctl;
    i_instruction = ins; i_instruction_valid = v.vld; i_uop_count = v.cnt;
    i_irq = v.irq; i_fiq = v.fiq;
    e.chk = v.chk; e.tag = tag; e.ins = {v.e_idx, ins};
    e.vld = v.e_vld; e.last = v.e_last; e.stall = v.e_stall; e.irq = v.e_irq; e.fiq = v.e_fiq;
    exp_q.push_back(e);
    @(negedge i_clk);
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty tag=%0d", tag);
    end else begin
      g = exp_q.pop_front();
      if (g.chk) begin
        total++;
        if (o_instruction !== g.ins || o_instruction_valid !== g.vld ||
            o_last_uop !== g.last || o_stall_from_decode !== g.stall ||
            o_irq !== g.irq || o_fiq !== g.fiq) begin
          bad++;
          $display("FAIL vec%0d got ins=%h v=%b l=%b s=%b irq=%b fiq=%b want ins=%h v=%b l=%b s=%b irq=%b fiq=%b",
                   g.tag, o_instruction, o_instruction_valid, o_last_uop, o_stall_from_decode,
                   o_irq, o_fiq, g.ins, g.vld, g.last, g.stall, g.irq, g.fiq);
        end
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int tag;
    int eff;
    logic q;
    // ctl vld cnt irq fiq | idx vld last stall irq fiq | chk
    tbl.push_back(mk(RST,      0,0,1,0, 0,0,0,0,1,0, 0));
    tbl.push_back(mk(RST,      0,0,1,0, 0,0,0,0,1,0, 1)); // reset state
    tbl.push_back(mk(C0,       0,0,0,1, 0,0,0,0,0,1, 1));
    tbl.push_back(mk(C0,       1,2,1,0, 0,1,0,1,1,0, 1)); // count 2
    tbl.push_back(mk(C0,       1,2,1,0, 1,1,1,0,0,0, 1));
    tbl.push_back(mk(C0,       1,1,1,0, 0,1,1,0,1,0, 1));
    tbl.push_back(mk(C0,       1,4,0,0, 0,1,0,1,0,0, 1)); // count 4, issue stall
    tbl.push_back(mk(SIS,      1,4,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,4,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,1,0,0, 2,1,0,1,0,0, 1)); // count change ignored
    tbl.push_back(mk(C0,       0,1,0,0, 3,0,1,0,0,0, 1)); // busy ignores valid
    tbl.push_back(mk(C0,       0,3,0,0, 0,0,0,0,0,0, 1)); // invalid: no start
    tbl.push_back(mk(C0,       1,3,0,1, 0,1,0,1,0,1, 1)); // count 3, alu clear
    tbl.push_back(mk(CALU,     1,3,0,1, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,1,0,1, 0,1,1,0,0,1, 1));
    tbl.push_back(mk(C0,       1,3,0,0, 0,1,0,1,0,0, 1)); // stall vs clear priority
    tbl.push_back(mk(DST|CALU, 1,3,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(SSH,      1,3,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(CWB|DST,  1,3,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,0,0,0, 0,1,1,0,0,0, 1)); // count 0
    tbl.push_back(mk(C0,       1,7,0,0, 0,1,0,1,0,0, 1)); // count 7 saturates
    tbl.push_back(mk(C0,       1,7,0,0, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,7,0,0, 2,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       1,7,0,0, 3,1,1,0,0,0, 1));
    tbl.push_back(mk(C0,       1,5,1,1, 0,1,0,1,1,1, 1)); // reset at index 2
    tbl.push_back(mk(C0,       1,5,1,1, 1,1,0,1,0,0, 1));
    tbl.push_back(mk(RST,      1,5,1,1, 2,1,0,1,0,0, 1));
    tbl.push_back(mk(C0,       0,5,1,0, 0,0,0,0,1,0, 1));
    tbl.push_back(mk(CWB,      1,2,0,0, 0,1,0,1,0,0, 1)); // clear blocks entry
    tbl.push_back(mk(C0,       1,1,0,0, 0,1,1,0,0,0, 1));
    tbl.push_back(mk(C0,       1,2,0,0, 0,1,0,1,0,0, 1)); // stall on last index
    tbl.push_back(mk(SIS,      1,2,0,0, 1,1,1,0,0,0, 1));
    tbl.push_back(mk(C0,       1,2,0,0, 1,1,1,0,0,0, 1));
    tbl.push_back(mk(C0,       0,2,0,0, 0,0,0,0,0,0, 1));

    i_reset = 1'b1; i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
    i_stall_from_shifter = 0; i_stall_from_issue = 0; i_instruction = '0;
    i_instruction_valid = 0; i_uop_count = '0; i_irq = 0; i_fiq = 0;
    @(posedge i_clk);
    #1;

    tag = 0;
    foreach (tbl[k]) begin
      step(tbl[k], tag);
      tag++;
    end

    // Hand-written sweep over every count: full expansion, no stalls.
    for (int n = 0; n < 8; n++) begin
      eff = (n == 0) ? 1 : ((n > MU) ? MU : n);
      q   = n[0];
      for (int k = 0; k < eff; k++) begin
        step(mk(C0, 1, 3'(n), q, ~q, 2'(k), 1, (k == eff - 1), (k != eff - 1),
                (k == 0) ? q : 1'b0, (k == 0) ? ~q : 1'b0, 1), tag);
        tag++;
      end
    end

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zap_predecode_uop_sequencer.md
ZAP_PREDECODE_UOP_SEQUENCER -- requirements
Module: zap_predecode_uop_sequencer

Interface
REQ-001 Parameter INST_WIDTH, default 35, SHALL set the width of the incoming instruction word, including its flag bits.
REQ-002 Parameter MAX_UOPS, default 4, minimum 2, SHALL set the maximum number of micro-ops one instruction may expand into.
REQ-003 Derived constant IDX_W = clog2(MAX_UOPS) SHALL set the width of the micro-op index.
REQ-004 i_clk  in  1  clock.
REQ-005 i_reset  in  1  reset: synchronous, active-high, on i_clk.
REQ-006 i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue  in  1 each  pipeline clears and stalls.
REQ-007 i_instruction  in  INST_WIDTH  instruction from the previous stage.
REQ-008 i_instruction_valid  in  1  instruction qualifier.
REQ-009 i_uop_count  in  IDX_W+1  number of micro-ops required, from the upstream classifier.
REQ-010 i_irq, i_fiq  in  1 each  incoming interrupts.
REQ-011 o_instruction  out  INST_WIDTH+IDX_W  {micro-op index, i_instruction}.
REQ-012 o_instruction_valid  out  1  output qualifier.
REQ-013 o_last_uop  out  1  high on the final micro-op of an instruction.
REQ-014 o_stall_from_decode  out  1  holds the upstream stage.
REQ-015 o_irq, o_fiq  out  1 each  gated interrupts.

Function
REQ-016 All outputs SHALL be combinational from state and inputs; the state SHALL be state_ff (IDLE/BUSY), idx_ff (IDX_W bits) and cnt_ff (IDX_W+1 bits).
REQ-017 Effective count SHALL be computed as: 0 → 1, greater than MAX_UOPS → MAX_UOPS, otherwise i_uop_count.
REQ-018 In IDLE, o_instruction SHALL be {0, i_instruction}, o_instruction_valid SHALL equal i_instruction_valid, and o_irq/o_fiq SHALL pass through.
REQ-019 In IDLE with valid and effective count 1: o_last_uop=1, stall=0, no state change.
REQ-020 In IDLE with valid and effective count ≥2: o_last_uop=0, stall=1; on advance, next state BUSY, idx_ff←1, cnt_ff←effective count.
REQ-021 In BUSY: o_instruction={idx_ff, i_instruction}, o_instruction_valid=i_instruction_valid, o_irq=o_fiq=0.
REQ-022 In BUSY with idx_ff < cnt_ff−1: stall=1, o_last_uop=0; on advance, idx_ff increments.
REQ-023 In BUSY with idx_ff = cnt_ff−1: stall=0, o_last_uop=1; on advance, next state IDLE and idx_ff←0.
REQ-024 State update priority, highest first: i_reset → IDLE; i_clear_from_writeback → IDLE; i_data_stall → hold; i_clear_from_alu → IDLE; i_stall_from_shifter → hold; i_stall_from_issue → hold; otherwise advance.
REQ-025 Every return to IDLE through a clear SHALL also zero idx_ff and cnt_ff, abandoning any partially issued expansion.
REQ-026 i_uop_count SHALL be sampled only on IDLE→BUSY entry; changes while in BUSY SHALL be ignored.
REQ-027 A valid 0 input in IDLE SHALL NOT start an expansion; in BUSY, sequencing SHALL continue irrespective of valid, because upstream is held.

Reset
REQ-028 On i_reset: state_ff=IDLE, idx_ff=0, cnt_ff=0.
REQ-029 With i_instruction_valid=0 after reset: o_instruction_valid=0, o_stall_from_decode=0, o_last_uop=0, o_instruction={0, i_instruction}, and o_irq/o_fiq follow the inputs.

Structure
REQ-030 State encodings IDLE=0 and BUSY=1 SHALL live in the shared predecode package, with the count-saturation rule implemented as a function in that package.
REQ-031 The block SHALL be one flat module with no sub-modules; the index counter is inline.

Verification
REQ-032 Count 2, no stalls → index 0 with stall=1, then index 1 with stall=0 and last=1, then IDLE; irq=1 throughout → o_irq=0 only in cycle 2.
REQ-033 MAX_UOPS=4, count 4, i_stall_from_issue high in cycle 2 → index 1 presented for 2 cycles, then indices 2 and 3; last=1 only on index 3.
REQ-034 Count 3, i_clear_from_alu in cycle 2 → IDLE next cycle with idx_ff=0; next instruction (count 1) issues with index 0 and last=1.
REQ-035 i_data_stall and i_clear_from_alu asserted together in BUSY → state held; i_clear_from_writeback and i_data_stall together → IDLE.
REQ-036 Count 0 → single micro-op with last=1; count 7 with MAX_UOPS=4 → exactly 4 micro-ops, indices 0–3.
REQ-037 i_reset asserted in BUSY at index 2 → IDLE, idx_ff=0 and cnt_ff=0 on the next edge; outputs match REQ-029.
